pingpong_buf: RTL and testbench
===============================

// Module: pingpong_buf
// PURPOSE
//  Two-entry ping-pong buffer that feeds mux2. Accepts WIDTH-bit words through a valid/ready handshake.
//  Holds the words in two banks, driven on d0/d1, and drives select s so that mux2 output y is the oldest word.
//  Sits directly upstream of mux2: connect d0->d0, d1->d1, s->s; y is the buffer's read data.
// PARAMETERS
//  WIDTH  8  data word width in bits (d0, d1, din)
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      synchronous, active-high reset
//  din        in   WIDTH  write data
//  in_valid   in   1      producer presents din this cycle
//  in_ready   out  1      buffer can accept a word (count != 2)
//  out_ready  in   1      consumer takes the word at mux2.y this cycle
//  out_valid  out  1      mux2.y holds a valid word (count != 0)
//  d0         out  WIDTH  bank 0 contents, to mux2.d0
//  d1         out  WIDTH  bank 1 contents, to mux2.d1
//  s          out  1      read pointer, to mux2.s (0 selects d0, 1 selects d1)
//  count      out  2      occupancy, 0..2
//  ovf_err    out  1      sticky: push attempted while full
// BEHAVIOUR
//  One clock domain. Reset is synchronous and active-high; state changes only on posedge clk.
//  State registers: bank0, bank1, wr_ptr (1b), rd_ptr (1b), count (2b), ovf_err.
//  Reset (reset=1 at posedge): wr_ptr=0, rd_ptr=0, count=0, d0=0, d1=0, ovf_err=0.
//   Outputs therefore read in_ready=1, out_valid=0, s=0.
//   Reset has priority over any push or pop in the same cycle.
//   Reset mid-operation discards all held words.
//  Combinational outputs: in_ready=(count!=2); out_valid=(count!=0); s=rd_ptr; d0=bank0; d1=bank1.
//  push = in_valid & in_ready:
//   - write din into bank[wr_ptr];
//   - toggle wr_ptr.
//  pop = out_valid & out_ready:
//   - toggle rd_ptr;
//   - the bank is NOT cleared and keeps its stale data.
//  count update:
//   - +1 on push only;
//   - -1 on pop only;
//   - unchanged on push&pop or on neither.
//  Latency: a word pushed in cycle N appears at mux2.y with out_valid=1 in cycle N+1. There is no
//   same-cycle bypass.
//  Empty (count=0): out_valid=0, so out_ready is ignored. s still equals rd_ptr.
//   d0/d1 hold stale data and the consumer must ignore it.
//  Full (count=2): in_ready=0, so din is ignored and the banks are unchanged.
//   A pop in the same cycle does not enable a push; in_ready is based on current count only.
//  count=1 with push&pop together:
//   - the new word goes to bank[wr_ptr];
//   - the head advances to that same bank next cycle;
//   - count stays 1.
//  Pointer wrap: the 1-bit pointers toggle 0->1->0. Order is strictly FIFO across wraps.
//  ovf_err: set to 1 at posedge when in_valid=1 and in_ready=0. It stays 1 until reset.
//  Producer and consumer may drop valid/ready at any time without penalty.
//  in_ready does not depend on in_valid, and out_valid does not depend on out_ready (no comb loops).
// TESTING
//  T1 reset:
//   - hold reset 2 cycles with in_valid=1, din=FF;
//   - expect count=0, d0=d1=00, s=0, in_ready=1, out_valid=0, ovf_err=0.
//  T2 order:
//   - push A5, then push 3C, out_ready=0;
//   - expect d0=A5, d1=3C, count=2, in_ready=0, y=A5;
//   - pop; expect s=1, y=3C, count=1.
//  T3 full:
//   - at count=2 drive in_valid=1, din=77;
//   - expect banks unchanged, count=2, ovf_err=1;
//   - ovf_err stays 1 after draining both words.
//  T4 simultaneous push&pop:
//   - at count=1 with head=11, push 22 and pop in the same cycle;
//   - expect count=1 and y=22 next cycle.
//   - At count=0, set out_ready=1 and push 33; expect no pop, count=1.
//  T5 wrap: stream 01..08 with in_valid=out_ready=1; expect y sequence 01..08 in order, s toggling.
//  T6 reset mid-op: at count=2, assert reset with push&pop asserted; expect the full T1 state next cycle.

Source files
------------

// File: rtl/pingpong_buf_if.sv
// pingpong_buf_if: producer/consumer handshake and mux2 feed signals of the ping-pong buffer
interface pingpong_buf_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] din;
  logic             in_valid;
  logic             in_ready;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic             s;
  logic [1:0]       count;
  logic             ovf_err;
  modport master (
    output din, in_valid, out_ready,
    input  in_ready, out_valid, d0, d1, s, count, ovf_err
  );
  modport slave (
    input  din, in_valid, out_ready,
    output in_ready, out_valid, d0, d1, s, count, ovf_err
  );
endinterface

// File: rtl/pingpong_buf.sv
// pingpong_buf: two-bank FIFO whose read pointer drives mux2.s so mux2.y is the oldest word
module pingpong_buf #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  pingpong_buf_if.slave  bus
);
  logic [WIDTH-1:0] bank0_q, bank0_d, bank1_q, bank1_d;
  logic             wr_q, wr_d, rd_q, rd_d, ovf_q, ovf_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             push, pop;
  assign bus.in_ready  = cnt_q != 2'd2;
  assign bus.out_valid = cnt_q != 2'd0;
  assign bus.s         = rd_q;
  assign bus.d0        = bank0_q;
  assign bus.d1        = bank1_q;
  assign bus.count     = cnt_q;
  assign bus.ovf_err   = ovf_q;
  // popped banks keep stale data; only the write pointer selects which bank is overwritten
  always_comb begin
    push    = bus.in_valid & bus.in_ready;
    pop     = bus.out_valid & bus.out_ready;
    bank0_d = (push & ~wr_q) ? bus.din : bank0_q;
    bank1_d = (push & wr_q) ? bus.din : bank1_q;
    wr_d    = wr_q ^ push;
    rd_d    = rd_q ^ pop;
    cnt_d   = cnt_q + {1'b0, push} - {1'b0, pop};
    ovf_d   = ovf_q | (bus.in_valid & ~bus.in_ready);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      bank0_q <= '0;
      bank1_q <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      cnt_q   <= 2'd0;
      ovf_q   <= 1'b0;
    end else begin
      bank0_q <= bank0_d;
      bank1_q <= bank1_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_pingpong_buf.sv
// tb_pingpong_buf: directed vector table, wrap stream and randomized run against a queue model
module tb_pingpong_buf;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  pingpong_buf_if #(.WIDTH(8)) bus();
  pingpong_buf #(.WIDTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic       r;
    logic       iv;
    logic [7:0] din;
    logic       o;
    logic [1:0] cnt;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       s;
    logic       ovf;
  } vec_t;
  vec_t vecs[14];
  logic [7:0] q[$];
  logic [7:0] mbank[2];
  int npush, npop;
  logic movf;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(input logic r, input logic iv, input logic [7:0] d, input logic o);
    reset = r;
    bus.in_valid = iv;
    bus.din = d;
    bus.out_ready = o;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [7:0] ysel();
    return bus.s ? bus.d1 : bus.d0;
  endfunction
  initial begin
    vecs = '{
      '{1, 1, 8'hFF, 0, 0, 8'h00, 8'h00, 0, 0},
      '{1, 1, 8'hFF, 0, 0, 8'h00, 8'h00, 0, 0},
      '{0, 1, 8'hA5, 0, 1, 8'hA5, 8'h00, 0, 0},
      '{0, 1, 8'h3C, 0, 2, 8'hA5, 8'h3C, 0, 0},
      '{0, 1, 8'h77, 0, 2, 8'hA5, 8'h3C, 0, 1},
      '{0, 0, 8'h00, 1, 1, 8'hA5, 8'h3C, 1, 1},
      '{0, 0, 8'h00, 1, 0, 8'hA5, 8'h3C, 0, 1},
      '{1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0},
      '{0, 1, 8'h11, 0, 1, 8'h11, 8'h00, 0, 0},
      '{0, 1, 8'h22, 1, 1, 8'h11, 8'h22, 1, 0},
      '{0, 0, 8'h00, 1, 0, 8'h11, 8'h22, 0, 0},
      '{0, 1, 8'h33, 1, 1, 8'h33, 8'h22, 0, 0},
      '{0, 1, 8'h44, 0, 2, 8'h33, 8'h44, 0, 0},
      '{1, 1, 8'h55, 1, 0, 8'h00, 8'h00, 0, 0}
    };
    bus.in_valid = 1'b0;
    bus.din = 8'h00;
    bus.out_ready = 1'b0;
    @(negedge clk);
    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].iv, vecs[i].din, vecs[i].o);
      chk($sformatf("v%0d count", i), 32'(bus.count), 32'(vecs[i].cnt));
      chk($sformatf("v%0d d0", i), 32'(bus.d0), 32'(vecs[i].d0));
      chk($sformatf("v%0d d1", i), 32'(bus.d1), 32'(vecs[i].d1));
      chk($sformatf("v%0d s", i), 32'(bus.s), 32'(vecs[i].s));
      chk($sformatf("v%0d ovf_err", i), 32'(bus.ovf_err), 32'(vecs[i].ovf));
      chk($sformatf("v%0d in_ready", i), 32'(bus.in_ready), 32'(vecs[i].cnt != 2'd2));
      chk($sformatf("v%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].cnt != 2'd0));
      if (vecs[i].cnt != 2'd0)
        chk($sformatf("v%0d y", i), 32'(ysel()), 32'(vecs[i].s ? vecs[i].d1 : vecs[i].d0));
    end
    drive(1, 0, 8'h00, 0);
    for (int k = 1; k <= 8; k++) begin
      drive(0, 1, 8'(k), 1);
      chk($sformatf("wrap y%0d", k), 32'(ysel()), 32'(k));
      chk($sformatf("wrap s%0d", k), 32'(bus.s), 32'((k - 1) % 2));
      chk($sformatf("wrap count%0d", k), 32'(bus.count), 32'd1);
    end
    drive(1, 0, 8'h00, 0);
    q.delete();
    mbank = '{8'h00, 8'h00};
    npush = 0;
    npop = 0;
    movf = 1'b0;
    for (int c = 0; c < 400; c++) begin
      logic r, iv, o;
      logic [7:0] d;
      int sz;
      r  = $urandom_range(0, 49) == 0;
      iv = $urandom_range(0, 2) != 0;
      o  = $urandom_range(0, 2) != 0;
      d  = 8'($urandom);
      sz = q.size();
      if (r) begin
        q.delete();
        mbank = '{8'h00, 8'h00};
        npush = 0;
        npop = 0;
        movf = 1'b0;
      end else begin
        if (iv && sz == 2) movf = 1'b1;
        if (o && sz > 0) begin
          void'(q.pop_front());
          npop++;
        end
        if (iv && sz < 2) begin
          q.push_back(d);
          mbank[npush % 2] = d;
          npush++;
        end
      end
      drive(r, iv, d, o);
      chk("rnd count", 32'(bus.count), 32'(q.size()));
      chk("rnd s", 32'(bus.s), 32'(npop % 2));
      chk("rnd d0", 32'(bus.d0), 32'(mbank[0]));
      chk("rnd d1", 32'(bus.d1), 32'(mbank[1]));
      chk("rnd ovf_err", 32'(bus.ovf_err), 32'(movf));
      chk("rnd in_ready", 32'(bus.in_ready), 32'(q.size() != 2));
      chk("rnd out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
      if (q.size() != 0) chk("rnd y", 32'(ysel()), 32'(q[0]));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
